// File: rtl/mer_pkg.sv
// Shared packet layout, mode and source encodings for the TC0 merge arbiter.
package mer_pkg;

    localparam int LR_W     = 1;
    localparam int NODE_W   = 16;
    localparam int GEN_W    = 12;
    localparam int OPR_W    = 32;
    localparam int UNI_W    = 1;
    localparam int MEMWEN_W = 2;
    localparam int PKT_W    = LR_W + NODE_W + GEN_W + OPR_W + UNI_W + MEMWEN_W;

    // Packet is {lr, node, gen, opr, uni_opr, mem_wen} with mem_wen in the LSBs.
    localparam int MEMWEN_LSB = 0;
    localparam int UNI_LSB    = MEMWEN_LSB + MEMWEN_W;
    localparam int OPR_LSB    = UNI_LSB + UNI_W;
    localparam int GEN_LSB    = OPR_LSB + OPR_W;
    localparam int NODE_LSB   = GEN_LSB + GEN_W;
    localparam int LR_LSB     = NODE_LSB + NODE_W;

    localparam int MODE_RR     = 0;
    localparam int MODE_PRIO_A = 1;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

    function automatic logic [PKT_W-1:0] clear_mem_wen(input logic [PKT_W-1:0] pkt);
        logic [PKT_W-1:0] res;
        res = pkt;
        res[MEMWEN_LSB +: MEMWEN_W] = '0;
        return res;
    endfunction

endpackage

// File: rtl/mer_in_buf.sv
// One-entry input buffer; accepts a new packet in the same cycle the old one pops.
module mer_in_buf
    import mer_pkg::*;
(
    input  logic             clka,
    input  logic             rst,
    input  logic             valid_i,
    input  logic             pop_i,
    input  logic [PKT_W-1:0] data_i,
    output logic             ready_o,
    output logic             full_o,
    output logic [PKT_W-1:0] data_o
);

    logic             full_q;
    logic [PKT_W-1:0] data_q;
    logic             push;

    assign ready_o = ~full_q | pop_i;
    assign push    = valid_i & ready_o;
    assign full_o  = full_q;
    assign data_o  = data_q;

    always_ff @(posedge clka) begin
        if (rst) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else if (push) begin
            full_q <= 1'b1;
            data_q <= data_i;
        end else if (pop_i) begin
            full_q <= 1'b0;
        end
    end

endmodule

// File: rtl/mer_arb.sv
// Two-input packet arbiter (A = Sw path, B = ICN path) feeding TC0 through a
// registered output, with round-robin or A-priority plus a burst limit.
module mer_arb
    import mer_pkg::*;
#(
    parameter int MODE      = 0,
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 16
) (
    input  logic             clka,
    input  logic             rst,
    input  logic             a_valid,
    input  logic [PKT_W-1:0] a_pkt,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [PKT_W-1:0] b_pkt,
    output logic             b_ready,
    output logic             out_valid,
    output logic [PKT_W-1:0] out_pkt,
    output logic             out_src,
    input  logic             out_ready,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] grant_cnt_a,
    output logic [CNT_W-1:0] grant_cnt_b
);

    localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

    logic [1:0]       side_valid, side_pop, side_ready, side_full;
    logic [PKT_W-1:0] side_pkt_in [2];
    logic [PKT_W-1:0] side_data   [2];

    logic             out_valid_q;
    logic [PKT_W-1:0] out_pkt_q;
    logic             out_src_q;
    logic             last_src_q;
    logic [3:0]       burst_q, burst_d;
    logic [CNT_W-1:0] cnt_a_q, cnt_b_q;

    logic             load;
    logic             grant_src;
    logic [PKT_W-1:0] granted_pkt;

    assign side_valid     = {b_valid, a_valid};
    assign side_pkt_in[0] = a_pkt;
    assign side_pkt_in[1] = b_pkt;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_buf
            mer_in_buf u_buf (
                .clka    (clka),
                .rst     (rst),
                .valid_i (side_valid[gi]),
                .pop_i   (side_pop[gi]),
                .data_i  (side_pkt_in[gi]),
                .ready_o (side_ready[gi]),
                .full_o  (side_full[gi]),
                .data_o  (side_data[gi])
            );
        end
    endgenerate

    assign a_ready = side_ready[0];
    assign b_ready = side_ready[1];

    always_comb begin
        load      = (~out_valid_q | out_ready) & (|side_full);
        grant_src = SRC_A;
        if (side_full == 2'b01) begin
            grant_src = SRC_A;
        end else if (side_full == 2'b10) begin
            grant_src = SRC_B;
        end else if (burst_q == BURST_MAX) begin
            // Burst limit overrides the mode so the waiting side is not starved.
            grant_src = ~last_src_q;
        end else if (MODE == MODE_RR) begin
            grant_src = ~last_src_q;
        end else begin
            grant_src = SRC_A;
        end

        side_pop = 2'b00;
        if (load) begin
            side_pop[grant_src] = 1'b1;
        end

        if (grant_src != last_src_q) begin
            burst_d = 4'd1;
        end else if (burst_q == BURST_MAX) begin
            burst_d = burst_q;
        end else begin
            burst_d = burst_q + 4'd1;
        end

        granted_pkt = (grant_src == SRC_A) ? clear_mem_wen(side_data[0]) : side_data[1];
    end

    always_ff @(posedge clka) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_pkt_q   <= '0;
            out_src_q   <= SRC_A;
            last_src_q  <= SRC_B;
            burst_q     <= 4'd0;
            cnt_a_q     <= '0;
            cnt_b_q     <= '0;
        end else begin
            if (load) begin
                out_valid_q <= 1'b1;
                out_pkt_q   <= granted_pkt;
                out_src_q   <= grant_src;
                last_src_q  <= grant_src;
                burst_q     <= burst_d;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end

            if (cnt_clr) begin
                cnt_a_q <= '0;
                cnt_b_q <= '0;
            end else if (load) begin
                if (grant_src == SRC_A) begin
                    cnt_a_q <= cnt_a_q + CNT_W'(1);
                end else begin
                    cnt_b_q <= cnt_b_q + CNT_W'(1);
                end
            end
        end
    end

    assign out_valid   = out_valid_q;
    assign out_pkt     = out_pkt_q;
    assign out_src     = out_src_q;
    assign grant_cnt_a = cnt_a_q;
    assign grant_cnt_b = cnt_b_q;

endmodule

// File: tb/tb_mer_arb.sv
// Bench for mer_arb: a round-robin and an A-priority instance, each checked
// against a grant-history reference model under directed and random traffic.
module tb_mer_arb;

    localparam int MB = 4;

    logic clka = 1'b0;
    always #5 clka = ~clka;

    logic        rst = 1'b1;
    logic        out_ready = 1'b1;
    logic        cnt_clr = 1'b0;
    logic        a_valid [2];
    logic        b_valid [2];
    logic [63:0] a_pkt   [2];
    logic [63:0] b_pkt   [2];
    logic        a_ready [2];
    logic        b_ready [2];
    logic        out_valid [2];
    logic [63:0] out_pkt [2];
    logic        out_src [2];
    logic [15:0] gca [2];
    logic [15:0] gcb [2];

    mer_arb #(.MODE(0), .MAX_BURST(MB), .CNT_W(16)) dut_rr (
        .clka(clka), .rst(rst),
        .a_valid(a_valid[0]), .a_pkt(a_pkt[0]), .a_ready(a_ready[0]),
        .b_valid(b_valid[0]), .b_pkt(b_pkt[0]), .b_ready(b_ready[0]),
        .out_valid(out_valid[0]), .out_pkt(out_pkt[0]), .out_src(out_src[0]),
        .out_ready(out_ready), .cnt_clr(cnt_clr),
        .grant_cnt_a(gca[0]), .grant_cnt_b(gcb[0])
    );

    mer_arb #(.MODE(1), .MAX_BURST(MB), .CNT_W(16)) dut_pa (
        .clka(clka), .rst(rst),
        .a_valid(a_valid[1]), .a_pkt(a_pkt[1]), .a_ready(a_ready[1]),
        .b_valid(b_valid[1]), .b_pkt(b_pkt[1]), .b_ready(b_ready[1]),
        .out_valid(out_valid[1]), .out_pkt(out_pkt[1]), .out_src(out_src[1]),
        .out_ready(out_ready), .cnt_clr(cnt_clr),
        .grant_cnt_a(gca[1]), .grant_cnt_b(gcb[1])
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Sources: one pending packet per DUT per side, held until accepted.
    bit          pv   [2][2];
    logic [63:0] pend [2][2];
    int          p_valid [2];
    int unsigned seq_id = 1;

    // Reference model: buffer contents, output register, counters, grant history.
    int          m_mode [2] = '{0, 1};
    bit          m_full [2][2];
    logic [63:0] m_pkt  [2][2];
    bit          m_ov   [2];
    logic [63:0] m_opkt [2];
    bit          m_osrc [2];
    int          m_cnt  [2][2];
    bit          glog   [2][16];
    int          glen   [2];

    function automatic void decide(input int d, output bit load, output bit g);
        int run;
        bit last;
        load = (!m_ov[d] || out_ready) && (m_full[d][0] || m_full[d][1]);
        last = (glen[d] == 0) ? 1'b1 : glog[d][0];
        run = 0;
        while (run < glen[d] && glog[d][run] == glog[d][0]) run++;
        if (m_full[d][0] && !m_full[d][1])      g = 1'b0;
        else if (!m_full[d][0] && m_full[d][1]) g = 1'b1;
        else if (run >= MB)                     g = !last;
        else if (m_mode[d] == 0)                g = !last;
        else                                    g = 1'b0;
    endfunction

    task automatic cycle();
        bit ld [2];
        bit g  [2];
        bit push [2][2];
        bit rdy;
        logic [63:0] p;
        for (int d = 0; d < 2; d++) begin
            for (int s = 0; s < 2; s++) begin
                if (!pv[d][s] && $urandom_range(99) < p_valid[s]) begin
                    p = {$urandom, $urandom};
                    p[34:3] = seq_id;
                    seq_id++;
                    pv[d][s] = 1'b1;
                    pend[d][s] = p;
                end
            end
            a_valid[d] = pv[d][0] && !rst;
            b_valid[d] = pv[d][1] && !rst;
            a_pkt[d]   = pend[d][0];
            b_pkt[d]   = pend[d][1];
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            decide(d, ld[d], g[d]);
            for (int s = 0; s < 2; s++) begin
                rdy = !m_full[d][s] || (ld[d] && g[d] == 1'(s));
                if (!rst) chk($sformatf("d%0d_ready%0d", d, s), (s == 0) ? a_ready[d] : b_ready[d], 64'(rdy));
                push[d][s] = pv[d][s] && !rst && rdy;
            end
            if (rst) begin
                m_full[d] = '{0, 0};
                m_ov[d] = 0; m_opkt[d] = '0; m_osrc[d] = 0;
                m_cnt[d] = '{0, 0};
                glen[d] = 0;
            end else begin
                if (ld[d]) begin
                    m_ov[d]   = 1;
                    m_opkt[d] = g[d] ? m_pkt[d][1] : (m_pkt[d][0] & ~64'h3);
                    m_osrc[d] = g[d];
                    m_full[d][g[d]] = 0;
                    for (int i = 15; i > 0; i--) glog[d][i] = glog[d][i-1];
                    glog[d][0] = g[d];
                    if (glen[d] < 16) glen[d]++;
                end else if (out_ready) begin
                    m_ov[d] = 0;
                end
                if (cnt_clr) m_cnt[d] = '{0, 0};
                else if (ld[d]) m_cnt[d][g[d]] = (m_cnt[d][g[d]] + 1) & 16'hFFFF;
                for (int s = 0; s < 2; s++) begin
                    if (push[d][s]) begin
                        m_full[d][s] = 1;
                        m_pkt[d][s]  = pend[d][s];
                    end
                end
            end
        end
        @(posedge clka);
        @(negedge clka);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d_out_valid", d), out_valid[d], 64'(m_ov[d]));
            if (m_ov[d]) begin
                chk($sformatf("d%0d_out_pkt", d), out_pkt[d], m_opkt[d]);
                chk($sformatf("d%0d_out_src", d), out_src[d], 64'(m_osrc[d]));
            end
            chk($sformatf("d%0d_cnt_a", d), gca[d], 64'(m_cnt[d][0]));
            chk($sformatf("d%0d_cnt_b", d), gcb[d], 64'(m_cnt[d][1]));
            if (ld[d] && !rst)
                $display("[%0t] dut%0d grant src=%0d pkt=%h", $time, d, out_src[d], out_pkt[d]);
            for (int s = 0; s < 2; s++) if (push[d][s]) pv[d][s] = 0;
        end
    endtask

    int          n [2];
    bit          sq [2][10];
    bit          found;
    logic [63:0] held;
    logic [1:0]  wen;

    initial begin
        p_valid = '{0, 0};
        @(negedge clka);

        // Reset held for three cycles.
        rst = 1'b1;
        repeat (3) cycle();
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            chk("rst_out_valid", out_valid[d], 64'd0);
            chk("rst_a_ready", a_ready[d], 64'd1);
            chk("rst_b_ready", b_ready[d], 64'd1);
            chk("rst_cnt_a", gca[d], 64'd0);
            chk("rst_cnt_b", gcb[d], 64'd0);
        end

        // Both sides saturated: grant order and counters.
        p_valid = '{100, 100};
        n = '{0, 0};
        for (int c = 0; c < 40 && (n[0] < 10 || n[1] < 10); c++) begin
            cycle();
            for (int d = 0; d < 2; d++) begin
                if (out_valid[d] && n[d] < 10) begin
                    sq[d][n[d]] = out_src[d];
                    n[d]++;
                    if (d == 0 && n[0] == 8) begin
                        chk("rr_cnt_a_8", gca[0], 64'd4);
                        chk("rr_cnt_b_8", gcb[0], 64'd4);
                    end
                    if (d == 1 && n[1] == 10) begin
                        chk("pa_cnt_a_10", gca[1], 64'd8);
                        chk("pa_cnt_b_10", gcb[1], 64'd2);
                    end
                end
            end
        end
        chk("rr_grants_seen", 64'(n[0]), 64'd10);
        chk("pa_grants_seen", 64'(n[1]), 64'd10);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("rr_src_%0d", i), 64'(sq[0][i]), 64'(i % 2));
            chk($sformatf("pa_src_%0d", i), 64'(sq[1][i]), 64'((i % 5) == 4));
        end

        // mem_wen stripping on A, B passes through untouched.
        p_valid = '{0, 0};
        repeat (6) cycle();
        for (int d = 0; d < 2; d++) begin
            pv[d][0] = 1'b1;
            pend[d][0] = 64'hA5A5_0000_1234_5673;
        end
        found = 0;
        for (int c = 0; c < 6 && !found; c++) begin
            cycle();
            if (out_valid[0]) found = 1;
        end
        chk("a_wen_seen", 64'(found), 64'd1);
        wen = out_pkt[0][1:0];
        chk("a_wen_zero", 64'(wen), 64'd0);
        chk("a_wen_pkt", out_pkt[0], 64'hA5A5_0000_1234_5670);
        chk("a_wen_src", 64'(out_src[0]), 64'd0);
        for (int d = 0; d < 2; d++) begin
            pv[d][1] = 1'b1;
            pend[d][1] = 64'hDEAD_BEEF_0123_4567;
        end
        found = 0;
        for (int c = 0; c < 6 && !found; c++) begin
            cycle();
            if (out_valid[0] && out_src[0]) found = 1;
        end
        chk("b_pass_seen", 64'(found), 64'd1);
        chk("b_pass_pkt", out_pkt[0], 64'hDEAD_BEEF_0123_4567);

        // Output stall for five cycles.
        p_valid = '{100, 100};
        repeat (3) cycle();
        out_ready = 1'b0;
        cycle();
        held = out_pkt[0];
        repeat (4) begin
            cycle();
            chk("stall_pkt_stable", out_pkt[0], held);
        end
        chk("stall_valid", out_valid[0], 64'd1);
        chk("stall_a_ready", a_ready[0], 64'd0);
        chk("stall_b_ready", b_ready[0], 64'd0);
        out_ready = 1'b1;
        repeat (10) cycle();

        // Reset with output valid and both buffers full.
        out_ready = 1'b0;
        repeat (3) cycle();
        chk("pre_rst_valid", out_valid[0], 64'd1);
        chk("pre_rst_a_full", a_ready[0], 64'd0);
        rst = 1'b1;
        cycle();
        for (int d = 0; d < 2; d++) begin
            chk("mid_rst_valid", out_valid[d], 64'd0);
            chk("mid_rst_a_ready", a_ready[d], 64'd1);
            chk("mid_rst_b_ready", b_ready[d], 64'd1);
        end
        rst = 1'b0;
        out_ready = 1'b1;

        // Random traffic, back-pressure and counter clears.
        for (int c = 0; c < 1500; c++) begin
            if (c % 200 == 0) p_valid = '{$urandom_range(100), $urandom_range(100)};
            out_ready = ($urandom_range(99) < 75);
            cnt_clr   = ($urandom_range(99) < 3);
            cycle();
        end
        cnt_clr = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
